instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage plus IF/ID pipeline register for the RV32IM pipeline. It holds the program counter, issues word reads to instruction memory under a busy-wait handshake, and registers the fetched word and its PC into IF/ID. `INSTRUCTION` drives `control_unit.INSTRUCTION` directly. It supports stall, branch/jump redirect with flush, and buffers one word fetched while the stage is held.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `NOP_WORD`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`) placed in IF/ID.
- `CLK` in 1: pipeline clock. All state updates on its rising edge.
- `RESET` in 1: synchronous, active-high reset, sampled on the rising edge of `CLK`.
- `BRANCH_TAKEN` in 1: redirect request from EX.
- `BRANCH_TARGET` in 32: redirect address. Bits [1:0] are ignored and treated as 0.
- `HOLD` in 1: stall from the hazard unit. Freezes PC and IF/ID.
- `IMEM_READ` out 1: read request. Combinational from state.
- `IMEM_ADDR` out 32: word address of the request. Bits [1:0] are always 0.
- `IMEM_INSTRUCTION` in 32: read data. Valid in a cycle where `IMEM_READ`=1 and `IMEM_BUSYWAIT`=0.
- `IMEM_BUSYWAIT` in 1: memory busy. A request completes at the clock edge where `IMEM_READ`=1 and `IMEM_BUSYWAIT`=0.
- `INSTRUCTION` out 32: IF/ID instruction register, to `control_unit`.
- `PC` out 32: IF/ID PC of `INSTRUCTION`.
- `PC_PLUS_4` out 32: IF/ID `PC`+4.
- `VALID` out 1: IF/ID holds a real instruction. When 0, `INSTRUCTION`=`NOP_WORD`.

## Operation
- Internal registers:
  - `pc_reg`: next fetch address.
  - `state`: FETCH, DRAIN, or BUFFERED.
  - `redirect_reg` (32 bits).
  - `buf_reg` (32 bits).
- Priority at every edge: `RESET` > `BRANCH_TAKEN` > `HOLD` > normal advance.
- **FETCH** (`IMEM_READ`=1, `IMEM_ADDR`=`pc_reg`):
  - Completion, no hold, no branch: IF/ID <= {`IMEM_INSTRUCTION`, `pc_reg`, `pc_reg`+4, VALID=1}; `pc_reg` <= `pc_reg`+4.
  - Completion with `HOLD`: IF/ID unchanged; `buf_reg` <= `IMEM_INSTRUCTION`; go to BUFFERED.
  - No completion (busy): IF/ID unchanged under `HOLD`. Otherwise IF/ID <= bubble (VALID=0, `INSTRUCTION`=`NOP_WORD`, `PC`/`PC_PLUS_4` unchanged).
  - `BRANCH_TAKEN`, memory idle (`IMEM_BUSYWAIT`=0): IF/ID <= bubble; `pc_reg` <= target; the fetched data is discarded; stay in FETCH.
  - `BRANCH_TAKEN`, memory busy: IF/ID <= bubble; `redirect_reg` <= target; go to DRAIN.
- **DRAIN** (`IMEM_READ`=1, `IMEM_ADDR` held at the old `pc_reg`; an in-flight request is never aborted):
  - IF/ID stays bubble.
  - A new `BRANCH_TAKEN` overwrites `redirect_reg`.
  - On completion: the data is discarded; `pc_reg` <= `redirect_reg`, or <= `BRANCH_TARGET` if `BRANCH_TAKEN` is high in that same cycle; go to FETCH.
- **BUFFERED** (`IMEM_READ`=0):
  - While `HOLD`=1: nothing changes.
  - When `HOLD`=0: IF/ID <= {`buf_reg`, `pc_reg`, `pc_reg`+4, 1}; `pc_reg` <= `pc_reg`+4; go to FETCH.
  - `BRANCH_TAKEN`: the buffer is discarded; IF/ID <= bubble; `pc_reg` <= target; go to FETCH.
- Arithmetic: all PC arithmetic is unsigned 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - `state`=FETCH; `pc_reg`=`RESET_PC`.
  - `INSTRUCTION`=`NOP_WORD`, `VALID`=0, `PC`=`RESET_PC`, `PC_PLUS_4`=`RESET_PC`+4.
  - `redirect_reg`=0, `buf_reg`=0.
  - `IMEM_READ`=0 while `RESET` is high.
- `RESET` asserted mid-operation (any state, memory busy or not) takes effect at that edge. The outstanding request is abandoned.
- First fetch: `IMEM_READ`=1 with `IMEM_ADDR`=`RESET_PC` in the first cycle after `RESET` deasserts.
- Latency: a word completing at edge N appears on `INSTRUCTION` after edge N.
- Throughput: with zero-wait memory, one instruction per cycle.
- Redirect cost: `BRANCH_TAKEN` at edge N with idle memory puts the target on `IMEM_ADDR` after N. Its instruction reaches IF/ID after N+1 at the earliest, so there is exactly one bubble.
- No combinational path from `IMEM_INSTRUCTION` or `BRANCH_*` to IF/ID outputs. Only `IMEM_READ` and `IMEM_ADDR` are combinational, and only from state/`pc_reg` plus `RESET`.

## Test plan
- **Reset and stream:** reset, zero-wait memory returning addr+0x100 as data.
  - `IMEM_ADDR` must go 0, 4, 8.
  - `INSTRUCTION` must be 0x100, 0x104, 0x108 on consecutive cycles, with `VALID`=1 and `PC`=0, 4, 8.
- **Busy-wait:** hold `IMEM_BUSYWAIT`=1 for 3 cycles on address 0x8.
  - `IMEM_ADDR` must stay 0x8 and IF/ID must show bubbles.
  - The word must be accepted once and `pc_reg` advance to 0xC.
- **Hold with buffer:** assert `HOLD` as the word at 0x10 completes, keep it 4 cycles.
  - `IMEM_READ` must be 0 and IF/ID frozen.
  - On release, the 0x10 word must enter IF/ID with no second read of 0x10.
- **Branch, memory idle:** `BRANCH_TAKEN` with target 0x200 at PC 0x20.
  - Exactly one `NOP_WORD` bubble, then an instruction with `PC`=0x200.
- **Branch during busy:** `BRANCH_TAKEN` with target 0x300 while the 0x24 read is busy, then a second target 0x400 one cycle later.
  - The 0x24 data must be discarded.
  - The next `IMEM_ADDR` must be 0x400.
  - `BRANCH_TARGET`=0x403 must produce `IMEM_ADDR`=0x400.
- **Wrap and reset mid-operation:** redirect to 0xFFFF_FFFC.
  - `IMEM_ADDR` must then wrap to 0x0.
  - Asserting `RESET` in DRAIN must restore all reset values at that edge.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage and IF/ID register: owns the PC, issues busy-wait word reads, handles stall,
// redirect with in-flight drain, and a one-word buffer for words that complete during a stall.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        HOLD,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_INSTRUCTION,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS_4,
  output logic        VALID
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    DRAIN    = 2'd1,
    BUFFERED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_reg;
  logic [31:0] redirect_reg;
  logic [31:0] buf_reg;

  logic [31:0] target;
  logic [31:0] pc_seq;
  logic [1:0]  unused_target_bits;

  assign target             = {BRANCH_TARGET[31:2], 2'b00};
  assign unused_target_bits = BRANCH_TARGET[1:0];
  assign pc_seq             = pc_reg + 32'd4;

  // pc_reg only ever receives word-aligned values, so it drives the address directly.
  assign IMEM_READ = !RESET && (state != BUFFERED);
  assign IMEM_ADDR = pc_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= FETCH;
      pc_reg       <= {RESET_PC[31:2], 2'b00};
      redirect_reg <= 32'd0;
      buf_reg      <= 32'd0;
      INSTRUCTION  <= NOP_WORD;
      VALID        <= 1'b0;
      PC           <= RESET_PC;
      PC_PLUS_4    <= RESET_PC + 32'd4;
    end else begin
      case (state)
        FETCH: begin
          if (BRANCH_TAKEN) begin
            INSTRUCTION <= NOP_WORD;
            VALID       <= 1'b0;
            if (!IMEM_BUSYWAIT) begin
              pc_reg <= target;
            end else begin
              redirect_reg <= target;
              state        <= DRAIN;
            end
          end else if (HOLD) begin
            // A word landing during a stall is parked so it is never re-read.
            if (!IMEM_BUSYWAIT) begin
              buf_reg <= IMEM_INSTRUCTION;
              state   <= BUFFERED;
            end
          end else if (!IMEM_BUSYWAIT) begin
            INSTRUCTION <= IMEM_INSTRUCTION;
            VALID       <= 1'b1;
            PC          <= pc_reg;
            PC_PLUS_4   <= pc_seq;
            pc_reg      <= pc_seq;
          end else begin
            INSTRUCTION <= NOP_WORD;
            VALID       <= 1'b0;
          end
        end

        DRAIN: begin
          // The in-flight read must finish; its data belongs to the squashed path.
          INSTRUCTION <= NOP_WORD;
          VALID       <= 1'b0;
          if (BRANCH_TAKEN) begin
            redirect_reg <= target;
          end
          if (!IMEM_BUSYWAIT) begin
            pc_reg <= BRANCH_TAKEN ? target : redirect_reg;
            state  <= FETCH;
          end
        end

        BUFFERED: begin
          if (BRANCH_TAKEN) begin
            INSTRUCTION <= NOP_WORD;
            VALID       <= 1'b0;
            pc_reg      <= target;
            state       <= FETCH;
          end else if (!HOLD) begin
            INSTRUCTION <= buf_reg;
            VALID       <= 1'b1;
            PC          <= pc_reg;
            PC_PLUS_4   <= pc_seq;
            pc_reg      <= pc_seq;
            state       <= FETCH;
          end
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal checks plus a
// transaction-level reference model compared every cycle.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        HOLD;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_INSTRUCTION;
  logic        IMEM_BUSYWAIT;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  logic [31:0] PC_PLUS_4;
  logic        VALID;

  instruction_fetch_unit dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .BRANCH_TAKEN     (BRANCH_TAKEN),
    .BRANCH_TARGET    (BRANCH_TARGET),
    .HOLD             (HOLD),
    .IMEM_READ        (IMEM_READ),
    .IMEM_ADDR        (IMEM_ADDR),
    .IMEM_INSTRUCTION (IMEM_INSTRUCTION),
    .IMEM_BUSYWAIT    (IMEM_BUSYWAIT),
    .INSTRUCTION      (INSTRUCTION),
    .PC               (PC),
    .PC_PLUS_4        (PC_PLUS_4),
    .VALID            (VALID)
  );

  always #5 CLK = ~CLK;

  // Memory image: every word reads as its own address plus 0x100.
  assign IMEM_INSTRUCTION = IMEM_ADDR + 32'h100;

  int tests = 0;
  int fails = 0;
  int rd10  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next fetch address, an optional pending redirect, and a queue
  // holding at most one word captured while stalled.
  logic [31:0] m_pc, m_pend, m_instr, m_pc_o, m_pc4;
  logic        m_valid;
  bit          m_drain;
  logic [31:0] m_buf_q[$];

  task automatic m_bubble();
    m_instr = NOP;
    m_valid = 1'b0;
  endtask

  task automatic m_retire(input logic [31:0] word, input logic [31:0] addr);
    m_instr = word;
    m_valid = 1'b1;
    m_pc_o  = addr;
    m_pc4   = addr + 32'd4;
    m_pc    = addr + 32'd4;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    logic [31:0] word;
    bit          reading;
    bit          done;
    tgt     = BRANCH_TARGET & 32'hFFFF_FFFC;
    word    = m_pc + 32'h100;
    reading = (m_buf_q.size() == 0);
    done    = reading && !IMEM_BUSYWAIT;
    if (RESET) begin
      m_pc = 32'd0; m_pend = 32'd0; m_drain = 0; m_buf_q.delete();
      m_instr = NOP; m_valid = 1'b0; m_pc_o = 32'd0; m_pc4 = 32'd4;
    end else if (m_drain) begin
      m_bubble();
      if (BRANCH_TAKEN) m_pend = tgt;
      if (done) begin
        m_pc    = m_pend;
        m_drain = 0;
      end
    end else if (!reading) begin
      if (BRANCH_TAKEN) begin
        m_buf_q.delete();
        m_bubble();
        m_pc = tgt;
      end else if (!HOLD) begin
        m_retire(m_buf_q.pop_front(), m_pc);
      end
    end else if (BRANCH_TAKEN) begin
      m_bubble();
      if (done) m_pc = tgt;
      else begin
        m_pend  = tgt;
        m_drain = 1;
      end
    end else if (HOLD) begin
      if (done) m_buf_q.push_back(word);
    end else if (done) begin
      m_retire(word, m_pc);
    end else begin
      m_bubble();
    end
  endtask

  always @(posedge CLK) begin
    if (!RESET && IMEM_READ && !IMEM_BUSYWAIT && IMEM_ADDR == 32'h10) rd10++;
    model_step();
    #1;
    chk("m_imem_read", {31'b0, IMEM_READ}, {31'b0, !RESET && m_buf_q.size() == 0});
    if (!RESET && m_buf_q.size() == 0) chk("m_imem_addr", IMEM_ADDR, m_pc);
    chk("m_instruction", INSTRUCTION, m_instr);
    chk("m_pc", PC, m_pc_o);
    chk("m_pc_plus_4", PC_PLUS_4, m_pc4);
    chk("m_valid", {31'b0, VALID}, {31'b0, m_valid});
  end

  initial begin
    RESET = 1'b1; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'd0; HOLD = 1'b0; IMEM_BUSYWAIT = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_instr", INSTRUCTION, 32'h13);
    chk("rst_valid", {31'b0, VALID}, 32'd0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_pc4", PC_PLUS_4, 32'h4);
    chk("rst_read", {31'b0, IMEM_READ}, 32'd0);
    RESET = 1'b0;
    #1;
    chk("first_read", {31'b0, IMEM_READ}, 32'd1);
    chk("first_addr", IMEM_ADDR, 32'h0);

    // Zero-wait stream
    @(negedge CLK);
    chk("s0_instr", INSTRUCTION, 32'h100); chk("s0_pc", PC, 32'h0);
    chk("s0_valid", {31'b0, VALID}, 32'd1); chk("s0_addr", IMEM_ADDR, 32'h4);
    @(negedge CLK);
    chk("s1_instr", INSTRUCTION, 32'h104); chk("s1_pc", PC, 32'h4); chk("s1_addr", IMEM_ADDR, 32'h8);
    @(negedge CLK);
    chk("s2_instr", INSTRUCTION, 32'h108); chk("s2_pc", PC, 32'h8); chk("s2_pc4", PC_PLUS_4, 32'hC);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst2_valid", {31'b0, VALID}, 32'd0); chk("rst2_instr", INSTRUCTION, 32'h13);
    chk("rst2_pc", PC, 32'h0); chk("rst2_read", {31'b0, IMEM_READ}, 32'd0);
    RESET = 1'b0;

    // Busy-wait on 0x8
    repeat (2) @(negedge CLK);
    chk("bw_addr0", IMEM_ADDR, 32'h8);
    IMEM_BUSYWAIT = 1'b1;
    @(negedge CLK);
    chk("bw_addr1", IMEM_ADDR, 32'h8); chk("bw_valid", {31'b0, VALID}, 32'd0);
    chk("bw_instr", INSTRUCTION, 32'h13); chk("bw_pc", PC, 32'h4);
    @(negedge CLK);
    chk("bw_addr2", IMEM_ADDR, 32'h8);
    @(negedge CLK);
    chk("bw_addr3", IMEM_ADDR, 32'h8); chk("bw_valid3", {31'b0, VALID}, 32'd0);
    IMEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    chk("bw_done_instr", INSTRUCTION, 32'h108); chk("bw_done_pc", PC, 32'h8);
    chk("bw_next_addr", IMEM_ADDR, 32'hC);

    // Hold as the 0x10 word completes
    @(negedge CLK);
    chk("h_pre_instr", INSTRUCTION, 32'h10C);
    HOLD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("h_read", {31'b0, IMEM_READ}, 32'd0);
      chk("h_instr", INSTRUCTION, 32'h10C);
      chk("h_pc", PC, 32'hC);
    end
    HOLD = 1'b0;
    @(negedge CLK);
    chk("h_rel_instr", INSTRUCTION, 32'h110); chk("h_rel_pc", PC, 32'h10);
    chk("h_rel_pc4", PC_PLUS_4, 32'h14); chk("h_rel_addr", IMEM_ADDR, 32'h14);
    chk("h_reads_of_10", rd10, 32'd1);

    // Branch with idle memory while fetching 0x20
    repeat (3) @(negedge CLK);
    chk("br_addr", IMEM_ADDR, 32'h20);
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h200;
    @(negedge CLK);
    chk("br_bubble_valid", {31'b0, VALID}, 32'd0); chk("br_bubble_instr", INSTRUCTION, 32'h13);
    chk("br_tgt_addr", IMEM_ADDR, 32'h200);
    BRANCH_TAKEN = 1'b0;
    @(negedge CLK);
    chk("br_instr", INSTRUCTION, 32'h300); chk("br_pc", PC, 32'h200);
    chk("br_valid", {31'b0, VALID}, 32'd1);
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h24;

    // Branch during a busy read of 0x24, then a second (unaligned) redirect
    @(negedge CLK);
    chk("bb_addr", IMEM_ADDR, 32'h24);
    BRANCH_TARGET = 32'h300; IMEM_BUSYWAIT = 1'b1;
    @(negedge CLK);
    chk("bb_drain_addr", IMEM_ADDR, 32'h24); chk("bb_drain_read", {31'b0, IMEM_READ}, 32'd1);
    chk("bb_drain_valid", {31'b0, VALID}, 32'd0);
    BRANCH_TARGET = 32'h403;
    @(negedge CLK);
    chk("bb_drain_addr2", IMEM_ADDR, 32'h24);
    BRANCH_TAKEN = 1'b0; IMEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    chk("bb_new_addr", IMEM_ADDR, 32'h400); chk("bb_discard_valid", {31'b0, VALID}, 32'd0);
    chk("bb_discard_instr", INSTRUCTION, 32'h13);
    @(negedge CLK);
    chk("bb_instr", INSTRUCTION, 32'h500); chk("bb_pc", PC, 32'h400);

    // Wrap from the top of the address space
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC;
    @(negedge CLK);
    chk("w_addr", IMEM_ADDR, 32'hFFFF_FFFC);
    BRANCH_TAKEN = 1'b0;
    @(negedge CLK);
    chk("w_instr", INSTRUCTION, 32'h0000_00FC); chk("w_pc", PC, 32'hFFFF_FFFC);
    chk("w_pc4", PC_PLUS_4, 32'h0); chk("w_addr_wrap", IMEM_ADDR, 32'h0);

    // Reset while draining
    IMEM_BUSYWAIT = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h600;
    @(negedge CLK);
    chk("rd_read", {31'b0, IMEM_READ}, 32'd1); chk("rd_addr", IMEM_ADDR, 32'h0);
    RESET = 1'b1; BRANCH_TAKEN = 1'b0;
    @(negedge CLK);
    chk("rd_rst_read", {31'b0, IMEM_READ}, 32'd0); chk("rd_rst_valid", {31'b0, VALID}, 32'd0);
    chk("rd_rst_instr", INSTRUCTION, 32'h13); chk("rd_rst_pc", PC, 32'h0);
    chk("rd_rst_pc4", PC_PLUS_4, 32'h4);
    RESET = 1'b0; IMEM_BUSYWAIT = 1'b0;
    #1;
    chk("rd_restart_addr", IMEM_ADDR, 32'h0);
    @(negedge CLK);
    chk("rd_restart_instr", INSTRUCTION, 32'h100); chk("rd_restart_pc", PC, 32'h0);

    // Mixed stalls, busy cycles and redirects, checked against the model
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      RESET         = ($urandom_range(0, 63) == 0);
      BRANCH_TAKEN  = ($urandom_range(0, 7) == 0);
      BRANCH_TARGET = $urandom & 32'h0000_0FFF;
      HOLD          = ($urandom_range(0, 3) == 0);
      IMEM_BUSYWAIT = ($urandom_range(0, 2) == 0);
    end
    @(negedge CLK);
    RESET = 1'b0; BRANCH_TAKEN = 1'b0; HOLD = 1'b0; IMEM_BUSYWAIT = 1'b0;
    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
